// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types and default 640x480 timing for the video output path
package video_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        PRIME    = 2'd1,
        RUN      = 2'd2
    } vid_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // One FIFO entry: the pixel plus the start-of-frame flag it arrived with.
    typedef struct packed {
        logic    sof;
        rgb888_t pix;
    } fifo_beat_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/axis_video_fifo.sv
// rtl/axis_video_fifo.sv - single-clock show-ahead FIFO with flush and occupancy count
// Ports: aclk/aresetn (sync, active-low); flush empties the FIFO and wins over
// any write in the same cycle; wr_en/wr_data push; rd_en pops; rd_data is the
// current head (valid while !empty); full, empty, count (0..DEPTH).
module axis_video_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A write into a full FIFO is allowed only when a pop frees the slot that cycle.
    assign do_wr   = wr_en && (!full || rd_en);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/axis_video_out.sv
// rtl/axis_video_out.sv - AXI-Stream pixel input to sync/de/RGB display timing output
// Ports: aclk (pixel clock), aresetn (sync, active-low); s_tdata/s_tvalid/
// s_tready/s_tlast/s_tuser pixel stream (tuser = start of frame, tlast unused);
// o_r/o_g/o_b pixel, o_hsync/o_vsync (active-low), o_de, o_locked.
// Build option AXIS_VIDEO_OUT_UNDERFLOW_EN adds o_underflow (sticky) and
// o_err_cnt (saturating count of underflow/misalignment events).
module axis_video_out
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [23:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    input  logic        s_tuser,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic        o_locked
`ifdef AXIS_VIDEO_OUT_UNDERFLOW_EN
    ,
    output logic        o_underflow,
    output logic [15:0] o_err_cnt
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] FULL_L = CW'(FIFO_DEPTH);

    vid_state_t    state;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;

    logic          active, origin, hs_on, vs_on;
    logic          accept, push, pop, serve, pix_ok;
    logic          underflow_ev, misalign_ev, err_ev;
    fifo_beat_t    wr_beat, head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count, count_n;
    logic          unused_tlast;

    // Alignment comes only from tuser at frame start; line ends are implied by timing.
    assign unused_tlast = s_tlast;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    assign active = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign origin = (hcnt == '0) && (vcnt == '0);
    assign hs_on  = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vs_on  = (vcnt >= VS_BEG) && (vcnt < VS_END);

    // PRIME serves the origin clock itself so the first pixel is not lost.
    assign serve        = active && ((state == RUN) || ((state == PRIME) && origin));
    assign underflow_ev = serve && fifo_empty;
    assign misalign_ev  = serve && !fifo_empty && head.sof && !origin;
    assign err_ev       = underflow_ev || misalign_ev;
    assign pop          = serve && !fifo_empty;
    assign pix_ok       = pop && !misalign_ev;

    assign accept  = s_tvalid && s_tready;
    assign push    = accept && ((state != WAIT_SOF) || s_tuser);
    assign wr_beat = {s_tuser, s_tdata};

    // Occupancy after this edge; s_tready is registered from it so a full
    // FIFO never sees a push it cannot take.
    assign count_n = err_ev ? '0
                   : fifo_count + CW'(push && (!fifo_full || pop)) - CW'(pop);

    axis_video_fifo #(
        .WIDTH ($bits(fifo_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .flush   (err_ev),
        .wr_en   (push),
        .wr_data (wr_beat),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= WAIT_SOF;
            s_tready <= 1'b0;
        end else if (err_ev) begin
            state    <= WAIT_SOF;
            s_tready <= 1'b1;
        end else begin
            case (state)
                WAIT_SOF: begin
                    if (accept && s_tuser) begin
                        state    <= PRIME;
                        s_tready <= (count_n != FULL_L);
                    end else begin
                        s_tready <= 1'b1;
                    end
                end
                PRIME: begin
                    if (origin) begin
                        state <= RUN;
                    end
                    s_tready <= (count_n != FULL_L);
                end
                RUN: begin
                    s_tready <= (count_n != FULL_L);
                end
                default: begin
                    state    <= WAIT_SOF;
                    s_tready <= 1'b1;
                end
            endcase
        end
    end

    assign o_locked = (state == RUN);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            o_de    <= 1'b0;
            o_hsync <= 1'b1;
            o_vsync <= 1'b1;
            o_r     <= '0;
            o_g     <= '0;
            o_b     <= '0;
        end else begin
            o_de    <= active;
            o_hsync <= !hs_on;
            o_vsync <= !vs_on;
            o_r     <= pix_ok ? head.pix.r : 8'd0;
            o_g     <= pix_ok ? head.pix.g : 8'd0;
            o_b     <= pix_ok ? head.pix.b : 8'd0;
        end
    end

`ifdef AXIS_VIDEO_OUT_UNDERFLOW_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            o_underflow <= 1'b0;
            o_err_cnt   <= '0;
        end else if (err_ev) begin
            o_underflow <= 1'b1;
            if (o_err_cnt != 16'hFFFF) begin
                o_err_cnt <= o_err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_video_out.sv
// tb/tb_axis_video_out.sv - randomized scoreboard bench for axis_video_out
module tb_axis_video_out;

    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 6,  VFP = 1, VSY = 2, VBP = 1;
    localparam int DEPTH = 8;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FR = HT * VT;
    localparam int M_HUNT = 0, M_PRIME = 1, M_RUN = 2;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [23:0] s_tdata;
    logic        s_tvalid, s_tready, s_tlast, s_tuser;
    logic [7:0]  o_r, o_g, o_b;
    logic        o_hsync, o_vsync, o_de, o_locked;
`ifdef AXIS_VIDEO_OUT_UNDERFLOW_EN
    logic        o_underflow;
    logic [15:0] o_err_cnt;
`endif

    always #5 aclk = ~aclk;

    axis_video_out #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .s_tuser  (s_tuser),
        .o_r      (o_r),
        .o_g      (o_g),
        .o_b      (o_b),
        .o_hsync  (o_hsync),
        .o_vsync  (o_vsync),
        .o_de     (o_de),
        .o_locked (o_locked)
`ifdef AXIS_VIDEO_OUT_UNDERFLOW_EN
        ,
        .o_underflow (o_underflow),
        .o_err_cnt   (o_err_cnt)
`endif
    );

    typedef struct packed {
        logic        hs, vs, de;
        logic [23:0] pix;
        logic        locked, tready, uf;
        logic [15:0] ec;
    } exp_t;

    typedef struct { logic [23:0] data; logic user; logic last; } sbeat_t;
    typedef struct { logic sof; logic [23:0] data; } mbeat_t;

    exp_t   exp_q[$];
    sbeat_t src_q[$];
    mbeat_t mq[$];

    int tests = 0, fails = 0;
    int n = 0, mode = M_HUNT, m_ec = 0;
    bit m_tready = 1'b0, m_uf = 1'b0;
    bit taken = 1'b0, stall = 1'b0, saw_bp = 1'b0, prev_lk = 1'b0;
    int rises = 0;

    task automatic check(input string name, input int got, input int need);
        tests++;
        if (got != need) begin
            fails++;
            $display("FAIL %s: got %0d, need %0d", name, got, need);
        end
    endtask

    // Reference model: display position from the clock count since reset,
    // stream content held as a plain queue of accepted beats.
    initial forever begin
        exp_t   e;
        mbeat_t b;
        int     h, v, old_mode;
        bit     act, org, err;
        logic [23:0] pix;
        @(posedge aclk);
        if (s_tvalid && s_tready) begin
            void'(src_q.pop_front());
            taken = 1'b1;
        end else begin
            taken = 1'b0;
        end
        if (s_tvalid && !s_tready && mode == M_RUN && !((n % HT) < HA && ((n / HT) % VT) < VA))
            saw_bp = 1'b1;
        if (o_locked && !prev_lk) rises++;
        prev_lk = o_locked;
        if (!aresetn) begin
            n = 0; mode = M_HUNT; mq.delete(); m_tready = 1'b0; m_uf = 1'b0; m_ec = 0;
            e = '{hs: 1'b1, vs: 1'b1, de: 1'b0, pix: 24'd0, locked: 1'b0,
                  tready: 1'b0, uf: 1'b0, ec: 16'd0};
        end else begin
            h = n % HT;
            v = (n / HT) % VT;
            act = (h < HA) && (v < VA);
            org = (h == 0) && (v == 0);
            err = 1'b0;
            pix = 24'd0;
            old_mode = mode;
            if (act && (old_mode == M_RUN || (old_mode == M_PRIME && org))) begin
                if (mq.size() == 0) err = 1'b1;
                else begin
                    b = mq.pop_front();
                    if (b.sof && !org) err = 1'b1;
                    else pix = b.data;
                end
            end
            if (s_tvalid && m_tready) begin
                if (old_mode == M_HUNT) begin
                    if (s_tuser) begin
                        mq.push_back('{1'b1, s_tdata});
                        mode = M_PRIME;
                    end
                end else begin
                    mq.push_back('{s_tuser, s_tdata});
                end
            end
            if (old_mode == M_PRIME && org) mode = M_RUN;
            if (err) begin
                mq.delete();
                mode = M_HUNT;
                m_uf = 1'b1;
                if (m_ec < 65535) m_ec++;
            end
            m_tready = (mode == M_HUNT) || (mq.size() < DEPTH);
            e.hs = !(h >= HA + HFP && h < HA + HFP + HSY);
            e.vs = !(v >= VA + VFP && v < VA + VFP + VSY);
            e.de = act;
            e.pix = pix;
            e.locked = (mode == M_RUN);
            e.tready = m_tready;
            e.uf = m_uf;
            e.ec = 16'(m_ec);
            n++;
        end
        exp_q.push_back(e);
    end

    // Monitor: one expected record per clock, compared just after the edge.
    initial begin
        int cyc = 0;
        forever begin
            exp_t e;
            @(posedge aclk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if ({o_hsync, o_vsync, o_de, o_r, o_g, o_b, o_locked, s_tready} !==
                    {e.hs, e.vs, e.de, e.pix, e.locked, e.tready}) begin
                    fails++;
                    $display("FAIL outputs cyc%0d: got hs=%0b vs=%0b de=%0b rgb=%06h lk=%0b rdy=%0b, need hs=%0b vs=%0b de=%0b rgb=%06h lk=%0b rdy=%0b",
                             cyc, o_hsync, o_vsync, o_de, {o_r, o_g, o_b}, o_locked, s_tready,
                             e.hs, e.vs, e.de, e.pix, e.locked, e.tready);
                end
`ifdef AXIS_VIDEO_OUT_UNDERFLOW_EN
                tests++;
                if ({o_underflow, o_err_cnt} !== {e.uf, e.ec}) begin
                    fails++;
                    $display("FAIL errflags cyc%0d: got uf=%0b cnt=%0d, need uf=%0b cnt=%0d",
                             cyc, o_underflow, o_err_cnt, e.uf, e.ec);
                end
`endif
            end
        end
    end

    // Driver: a presented beat is held until taken; random bubbles otherwise.
    initial forever begin
        @(negedge aclk);
        if (!(s_tvalid && !taken)) begin
            if (!stall && src_q.size() > 0 && $urandom_range(0, 7) != 0) begin
                s_tvalid = 1'b1;
                s_tdata  = src_q[0].data;
                s_tuser  = src_q[0].user;
                s_tlast  = src_q[0].last;
            end else begin
                s_tvalid = 1'b0;
            end
        end
    end

    task automatic push_frame(input bit ramp, input int inj_x, input int inj_y);
        sbeat_t b;
        for (int y = 0; y < VA; y++) begin
            for (int x = 0; x < HA; x++) begin
                b.data = ramp ? 24'(x) : 24'($urandom());
                b.user = (x == 0 && y == 0) || (x == inj_x && y == inj_y);
                b.last = (x == HA - 1);
                src_q.push_back(b);
            end
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            if (src_q.size() == 0) ok = 1'b1;
            else @(negedge aclk);
        end
        if (!ok) check(name, 0, 1);
    endtask

    task automatic wait_pos(input string name, input int v, input int h, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge aclk);
            if (mode == M_RUN && (n % HT) == h && ((n / HT) % VT) == v) ok = 1'b1;
        end
        if (!ok) check(name, 0, 1);
    endtask

    initial begin
        int de_n = 0, hs_n = 0, vs_n = 0, pix_n = 0, lk_n = 0, first_hs = -1;
        sbeat_t jb;
        aresetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk) aresetn = 1'b1;

        for (int k = 0; k < FR; k++) begin
            @(posedge aclk);
            #1;
            if (o_de) de_n++;
            if (!o_hsync) begin
                hs_n++;
                if (first_hs < 0) first_hs = k;
            end
            if (!o_vsync) vs_n++;
            if ({o_r, o_g, o_b} != 24'd0) pix_n++;
            if (o_locked) lk_n++;
        end
        check("idle_de_count", de_n, HA * VA);
        check("idle_hsync_low", hs_n, HSY * VT);
        check("idle_hsync_start", first_hs, HA + HFP);
        check("idle_vsync_low", vs_n, VSY * HT);
        check("idle_pixels", pix_n, 0);
        check("idle_locked", lk_n, 0);

        for (int j = 0; j < 3; j++) begin
            jb.data = 24'($urandom()); jb.user = 1'b0; jb.last = 1'b0;
            src_q.push_back(jb);
        end
        push_frame(1'b1, -1, -1);
        push_frame(1'b0, -1, -1);
        push_frame(1'b0, -1, -1);
        wait_drain("drain_ramp", 6 * FR);
        repeat (FR) @(negedge aclk);
        check("lock_rises_ramp", rises, 1);
`ifdef AXIS_VIDEO_OUT_UNDERFLOW_EN
        check("errcnt_ramp", int'(o_err_cnt), 1);
`endif

        push_frame(1'b0, -1, -1);
        push_frame(1'b0, -1, -1);
        push_frame(1'b0, -1, -1);
        wait_pos("stall_pos", 2, 5, 4 * FR);
        stall = 1'b1;
        repeat (30) @(negedge aclk);
        stall = 1'b0;
        wait_drain("drain_stall", 6 * FR);
        repeat (FR) @(negedge aclk);
        check("lock_rises_stall", rises, 3);
`ifdef AXIS_VIDEO_OUT_UNDERFLOW_EN
        check("underflow_sticky", int'(o_underflow), 1);
        check("errcnt_stall", int'(o_err_cnt), 3);
`endif

        push_frame(1'b0, 8, 3);
        push_frame(1'b0, -1, -1);
        push_frame(1'b0, -1, -1);
        wait_drain("drain_misalign", 6 * FR);
        repeat (FR) @(negedge aclk);
        check("lock_rises_misalign", rises, 5);
        check("backpressure_in_blanking", int'(saw_bp), 1);
`ifdef AXIS_VIDEO_OUT_UNDERFLOW_EN
        check("errcnt_misalign", int'(o_err_cnt), 5);
`endif

        push_frame(1'b0, -1, -1);
        push_frame(1'b0, -1, -1);
        push_frame(1'b0, -1, -1);
        wait_pos("reset_pos", 2, 5, 4 * FR);
        aresetn = 1'b0;
        @(negedge aclk) aresetn = 1'b1;
        wait_drain("drain_reset", 6 * FR);
        repeat (FR) @(negedge aclk);
        check("lock_rises_reset", rises, 7);
`ifdef AXIS_VIDEO_OUT_UNDERFLOW_EN
        check("errcnt_after_reset", int'(o_err_cnt), 1);
`endif

        repeat (4) @(negedge aclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
